simon_host: RTL

SIMON_HOST -- requirements
Module: simon_host

---
 rtl/simon_host_pkg.sv | 35 +++
 rtl/simon_host_if.sv | 21 ++
 rtl/simon_word_pack.sv | 37 +++
 rtl/simon_host.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/simon_host_pkg.sv
// Shared types and constants for the SIMON host adapter: FSM state encoding,
// command opcodes and the block/key word-count derivations.
package simon_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COLLECT   = 3'd1,
        ST_KEY_ISSUE = 3'd2,
        ST_KEY_WAIT  = 3'd3,
        ST_BLK_ISSUE = 3'd4,
        ST_BLK_WAIT  = 3'd5,
        ST_SEND      = 3'd6,
        ST_DISCARD   = 3'd7
    } state_e;

    localparam logic [1:0] OP_KEY = 2'd0;
    localparam logic [1:0] OP_ENC = 2'd1;
    localparam logic [1:0] OP_DEC = 2'd2;
    localparam logic [1:0] OP_ILL = 2'd3;

    // Host words per 2N-bit data block
    function automatic int calc_bw(input int n);
        return (n * 32'sd2) / 32'sd32;
    endfunction

    // Host words per M*N-bit key
    function automatic int calc_kw(input int n, input int m);
        return (m * n) / 32'sd32;
    endfunction

    function automatic int cnt_width(input int words);
        return (words > 32'sd1) ? $clog2(words) : 32'sd1;
    endfunction

endpackage

// File: rtl/simon_host_if.sv
// Host-side command and result streams of the SIMON host adapter.
interface simon_host_if;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

endinterface

// File: rtl/simon_word_pack.sv
// Word-indexed 32-bit load / full-width capture register with an indexed
// 32-bit read port; holds key, block and result in turn.
module simon_word_pack #(
    parameter int WORDS = 32'sd4,
    parameter int IW    = 32'sd2
) (
    input  logic                  clk,
    input  logic                  nR,
    input  logic                  load_en,
    input  logic [IW-1:0]         load_idx,
    input  logic [31:0]           load_word,
    input  logic                  cap_en,
    input  logic [WORDS*32-1:0]   cap_data,
    input  logic [IW-1:0]         sel_idx,
    output logic [WORDS*32-1:0]   vec,
    output logic [31:0]           sel_word
);

    logic [WORDS*32-1:0] vec_r;

    // Packed storage: whole-vector capture has priority over a single word load
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            vec_r <= '0;
        end else if (cap_en) begin
            vec_r <= cap_data;
        end else if (load_en) begin
            vec_r[{load_idx, 5'd0} +: 32] <= load_word;
        end else begin
            vec_r <= vec_r;
        end
    end

    assign vec      = vec_r;
    assign sel_word = vec_r[{sel_idx, 5'd0} +: 32];

endmodule

// File: rtl/simon_host.sv
// Host adapter between a 32-bit command/result stream pair and a SIMON cipher
// core: collects key/block payloads, hands them to the core, streams results.
module simon_host
    import simon_host_pkg::*;
#(
    parameter int N = 32'sd64,
    parameter int M = 32'sd2
) (
    input  logic              clk,
    input  logic              nR,
    simon_host_if.slave       host,
    output logic              newKey,
    output logic [M*N-1:0]    KEY,
    input  logic              loadKey,
    input  logic              doneKey,
    output logic              newData,
    output logic              enc_dec,
    output logic [2*N-1:0]    blockIN,
    input  logic              loadData,
    input  logic              doneData,
    input  logic [2*N-1:0]    outData,
    output logic              readData,
    output logic              busy,
    output logic              keyValid,
    output logic              err
);

    localparam int BW = calc_bw(N);
    localparam int KW = calc_kw(N, M);
    localparam int PW = (KW > BW) ? KW : BW;
    localparam int CW = cnt_width(PW);
    localparam logic [CW-1:0] BW_LAST = CW'(BW - 32'sd1);
    localparam logic [CW-1:0] KW_LAST = CW'(KW - 32'sd1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

    state_e            state_r;
    state_e            state_next_s;
    logic [CW-1:0]     cnt_r;
    logic [1:0]        op_r;
    logic              enc_dec_r;
    logic              key_valid_r;
    logic              err_r;
    logic              s_ready_r;
    logic              busy_r;
    logic              new_key_r;
    logic              new_data_r;
    logic              m_valid_r;
    logic              read_data_r;

    logic              s_xfer_s;
    logic              m_xfer_s;
    logic [1:0]        hdr_op_s;
    logic [CW-1:0]     collect_last_s;
    logic              cnt_adv_s;
    logic              hdr_take_s;
    logic              load_en_s;
    logic              cap_en_s;
    logic [PW*32-1:0]  cap_data_s;
    logic [PW*32-1:0]  vec_s;
    logic [31:0]       sel_word_s;

    assign s_xfer_s   = host.s_valid & s_ready_r;
    assign m_xfer_s   = m_valid_r & host.m_ready;
    assign hdr_op_s   = host.s_data[1:0];
    assign hdr_take_s = (state_r == ST_IDLE) & s_xfer_s;
    assign load_en_s  = (state_r == ST_COLLECT) & s_xfer_s;
    assign cap_en_s   = (state_r == ST_BLK_WAIT) & doneData;
    assign cnt_adv_s  = (((state_r == ST_COLLECT) || (state_r == ST_DISCARD)) && s_xfer_s)
                      || ((state_r == ST_SEND) && m_xfer_s);

    // Payload length of the command being collected
    always_comb begin
        collect_last_s = BW_LAST;
        if (op_r == OP_KEY) begin
            collect_last_s = KW_LAST;
        end else begin
            collect_last_s = BW_LAST;
        end
    end

    // Result is zero-extended when the shared register is wider than a block
    always_comb begin
        cap_data_s            = '0;
        cap_data_s[2*N-1:0]   = outData;
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (s_xfer_s) begin
                    case (hdr_op_s)
                        OP_KEY:         state_next_s = ST_COLLECT;
                        OP_ENC, OP_DEC: state_next_s = key_valid_r ? ST_COLLECT : ST_DISCARD;
                        OP_ILL:         state_next_s = ST_IDLE;
                        default:        state_next_s = ST_IDLE;
                    endcase
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (s_xfer_s && (cnt_r == collect_last_s)) begin
                    state_next_s = (op_r == OP_KEY) ? ST_KEY_ISSUE : ST_BLK_ISSUE;
                end else begin
                    state_next_s = ST_COLLECT;
                end
            end
            ST_KEY_ISSUE: state_next_s = loadKey  ? ST_KEY_WAIT : ST_KEY_ISSUE;
            ST_KEY_WAIT:  state_next_s = doneKey  ? ST_IDLE     : ST_KEY_WAIT;
            ST_BLK_ISSUE: state_next_s = loadData ? ST_BLK_WAIT : ST_BLK_ISSUE;
            ST_BLK_WAIT:  state_next_s = doneData ? ST_SEND     : ST_BLK_WAIT;
            ST_SEND: begin
                if (m_xfer_s && (cnt_r == BW_LAST)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_DISCARD: begin
                if (s_xfer_s && (cnt_r == BW_LAST)) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DISCARD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State, counter, command context and registered outputs decoded from the next state
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            op_r        <= OP_KEY;
            enc_dec_r   <= 1'b0;
            key_valid_r <= 1'b0;
            err_r       <= 1'b0;
            s_ready_r   <= 1'b0;
            busy_r      <= 1'b0;
            new_key_r   <= 1'b0;
            new_data_r  <= 1'b0;
            m_valid_r   <= 1'b0;
            read_data_r <= 1'b0;
        end else begin
            state_r <= state_next_s;

            if (state_next_s != state_r) begin
                cnt_r <= '0;
            end else if (cnt_adv_s) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end

            if (hdr_take_s) begin
                op_r <= hdr_op_s;
            end else begin
                op_r <= op_r;
            end

            if (hdr_take_s && key_valid_r && ((hdr_op_s == OP_ENC) || (hdr_op_s == OP_DEC))) begin
                enc_dec_r <= (hdr_op_s == OP_ENC);
            end else begin
                enc_dec_r <= enc_dec_r;
            end

            // The core owns the old key from the moment it captures a new one
            if ((state_r == ST_KEY_ISSUE) && loadKey) begin
                key_valid_r <= 1'b0;
            end else if ((state_r == ST_KEY_WAIT) && doneKey) begin
                key_valid_r <= 1'b1;
            end else begin
                key_valid_r <= key_valid_r;
            end

            if (hdr_take_s && ((hdr_op_s == OP_ILL) || ((hdr_op_s != OP_KEY) && !key_valid_r))) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end

            s_ready_r   <= (state_next_s == ST_IDLE) || (state_next_s == ST_COLLECT)
                         || (state_next_s == ST_DISCARD);
            busy_r      <= (state_next_s != ST_IDLE);
            new_key_r   <= (state_next_s == ST_KEY_ISSUE);
            new_data_r  <= (state_next_s == ST_BLK_ISSUE);
            m_valid_r   <= (state_next_s == ST_SEND);
            read_data_r <= cap_en_s;
        end
    end

    simon_word_pack #(
        .WORDS (PW),
        .IW    (CW)
    ) u_pack (
        .clk       (clk),
        .nR        (nR),
        .load_en   (load_en_s),
        .load_idx  (cnt_r),
        .load_word (host.s_data),
        .cap_en    (cap_en_s),
        .cap_data  (cap_data_s),
        .sel_idx   (cnt_r),
        .vec       (vec_s),
        .sel_word  (sel_word_s)
    );

    assign host.s_ready = s_ready_r;
    assign host.m_valid = m_valid_r;
    assign host.m_data  = sel_word_s;
    assign KEY          = vec_s[M*N-1:0];
    assign blockIN      = vec_s[2*N-1:0];
    assign newKey       = new_key_r;
    assign newData      = new_data_r;
    assign enc_dec      = enc_dec_r;
    assign readData     = read_data_r;
    assign busy         = busy_r;
    assign keyValid     = key_valid_r;
    assign err          = err_r;

endmodule
